cart_bank_mapper: RTL and testbench
===================================

CART_BANK_MAPPER -- requirements
Module: cart_bank_mapper

Interface
REQ-001 SHALL have parameter NUM_WINDOWS, default 3, number of banked windows (legal 1..7).
REQ-002 SHALL have parameter BANK_WIDTH, default 10, bank number width (legal 9..16).
REQ-003 SHALL have parameter REG_BASE, default 8'hD0, address of window 0 BANK_L.
REQ-004 SHALL have parameter EXT_BASE, default 8'hE4, address of the extension registers MASK_L, MASK_H, APPLY, LOCK (consecutive).
REQ-005 SHALL have parameter LINEAR_ADDR, default 8'hC0, address of the linear-offset register.
REQ-006 FastClk  in  1  sole clock; all state changes on its rising edge.
REQ-007 Reset  in  1  asynchronous, active-high reset.
REQ-008 nSel, nIO, nWE  in  1 each  console bus strobes, asynchronous to FastClk.
REQ-009 RegAddr  in  8  register address; WriteData  in  8  write byte.
REQ-010 AddrHi  in  4  memory-window selector.
REQ-011 ReadData  out  8  register read value; RegAck  out  1  address decodes to a register.
REQ-012 BankOut  out  BANK_WIDTH  translated bank; WindowHit  out  NUM_WINDOWS+1  one-hot hit (bit NUM_WINDOWS = linear).
REQ-013 Locked  out  1  extension registers are write-protected.

Function
REQ-014 nSel, nIO, nWE SHALL each pass a 2-flop synchroniser.
REQ-015 RegAddr/WriteData SHALL be captured on every cycle where synchronised nWE=0, nSel=0 and nIO=0.
REQ-016 A write SHALL commit on the cycle after synchronised nWE goes 0->1 with the last capture valid; the result SHALL be visible on outputs 3 FastClk cycles after nWE rises at the pins, ±1 cycle.
REQ-017 Window w BANK_L (REG_BASE+2w) writes SHALL only load staging byte stage[w].
REQ-018 Window w BANK_H (REG_BASE+2w+1) writes SHALL atomically load bank[w] = {WriteData[BANK_WIDTH-9:0], stage[w]}.
REQ-019 stage[w] SHALL persist after a commit; with repeated L writes the last one wins; an H-only write reuses the current stage.
REQ-020 MASK_L stages; MASK_H commits the mask atomically, with the same rules as REQ-017..019.
REQ-021 APPLY bits [NUM_WINDOWS:0] SHALL enable masking per window; the top enabled bit applies to linear.
REQ-022 LINEAR_ADDR SHALL hold an 8-bit linear offset.
REQ-023 Lock FSM: states LOCKED, KEY1, UNLOCKED.
REQ-024 LOCK FSM, LOCKED: 8'h4E -> KEY1.
REQ-025 LOCK FSM, KEY1: 8'h53 -> UNLOCKED; any other LOCK write -> LOCKED.
REQ-026 LOCK FSM, UNLOCKED: 8'h00 -> LOCKED.
REQ-027 Writes to any register other than LOCK SHALL not change FSM state.
REQ-028 MASK_L/MASK_H/APPLY writes while Locked=1 SHALL be ignored, including the mask staging byte.
REQ-029 Reads SHALL be combinational from RegAddr and state.
REQ-030 BANK_L SHALL read committed bank[w][7:0], not stage[w].
REQ-031 BANK_H SHALL read committed bank[w] upper bits, zero-extended.
REQ-032 MASK_L/MASK_H SHALL read like BANK_L/BANK_H; APPLY and LINEAR read their values, unused bits 0; LOCK reads {6'b0, FSM code}.
REQ-033 Unmapped RegAddr SHALL give RegAck=0 and ReadData=0.
REQ-034 Translation SHALL be combinational: AddrHi=0 -> WindowHit=0, BankOut=0.
REQ-035 AddrHi in 1..NUM_WINDOWS -> window AddrHi-1 with bank[AddrHi-1].
REQ-036 AddrHi>NUM_WINDOWS -> linear, raw bank = {linear, AddrHi} truncated to BANK_WIDTH.
REQ-037 BankOut SHALL equal raw & mask when the hit window's APPLY bit is 1, otherwise raw.

Reset
REQ-038 Reset SHALL set every bank[w] and stage[w] to all-ones; mask and mask stage to all-ones.
REQ-039 Reset SHALL set APPLY to all-ones, linear to 8'hFF, and the FSM to LOCKED.
REQ-040 Reset SHALL clear synchroniser flops to idle (1) and the capture-valid flag to 0.
REQ-041 Reset asserted mid-write SHALL discard the pending write; no partial commit.

Structure
REQ-042 Package cart_mapper_pkg SHALL hold the lock FSM enum, key constants 8'h4E/8'h53, and the extension-register offset constants.
REQ-043 One sub-module, bus_write_sync (synchroniser + edge detect + capture), SHALL be instantiated once.

Verification
REQ-044 Write D2=0x34 then D3=0x02 -> BankOut=0x234 with AddrHi=2 only after the D3 commit; BankOut unchanged between the two writes.
REQ-045 With reset defaults and Locked=1, write E4=0x0F, E5=0x00 -> mask unchanged; then LOCK 0x4E, 0x53, E4=0x0F, E5=0x00 -> AddrHi=3 gives BankOut=0x00F.
REQ-046 LOCK sequence 0x4E, 0x11, 0x53 -> Locked stays 1 and LOCK reads LOCKED.
REQ-047 With linear=0x12, AddrHi=7, APPLY=0 -> BankOut=0x127 and WindowHit=4'b1000; AddrHi=0 -> BankOut=0, WindowHit=0.
REQ-048 Assert Reset while nWE low during a D1 write -> bank[0] stays 0x3FF and no commit after release.
REQ-049 Read D0 after D0=0x55 with no D1 write -> ReadData=0xFF, RegAck=1; read 0xFF -> RegAck=0, ReadData=0.

Source files
------------

// File: rtl/cart_mapper_pkg.sv
// Shared types and constants for the cartridge bank mapper: lock FSM encoding,
// unlock key bytes and extension-register offsets from EXT_BASE.
package cart_mapper_pkg;

    typedef enum logic [1:0] {
        LK_LOCKED   = 2'd0,
        LK_KEY1     = 2'd1,
        LK_UNLOCKED = 2'd2
    } lock_state_e;

    localparam logic [7:0] LOCK_KEY1   = 8'h4E;
    localparam logic [7:0] LOCK_KEY2   = 8'h53;
    localparam logic [7:0] LOCK_RELOCK = 8'h00;

    localparam logic [7:0] EXT_MASK_L_OFS = 8'd0;
    localparam logic [7:0] EXT_MASK_H_OFS = 8'd1;
    localparam logic [7:0] EXT_APPLY_OFS  = 8'd2;
    localparam logic [7:0] EXT_LOCK_OFS   = 8'd3;

endpackage

// File: rtl/bus_write_sync.sv
// Brings the asynchronous console write strobes into the FastClk domain, captures
// address/data while the write is active and emits a one-cycle commit on nWE release.
module bus_write_sync (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       nsel_i,
    input  logic       nio_i,
    input  logic       nwe_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] data_i,
    output logic       wr_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o
);

    logic [1:0] sel_sync_q, io_sync_q, we_sync_q;
    logic       we_prev_q;
    logic       cap_vld_q;
    logic [7:0] addr_q, data_q;
    logic       strobe, rise;

    assign strobe = ~we_sync_q[1] & ~sel_sync_q[1] & ~io_sync_q[1];
    assign rise   = we_sync_q[1] & ~we_prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_sync_q <= 2'b11;
            io_sync_q  <= 2'b11;
            we_sync_q  <= 2'b11;
            we_prev_q  <= 1'b1;
            cap_vld_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            sel_sync_q <= {sel_sync_q[0], nsel_i};
            io_sync_q  <= {io_sync_q[0], nio_i};
            we_sync_q  <= {we_sync_q[0], nwe_i};
            we_prev_q  <= we_sync_q[1];
            // Bus is stable for the whole low phase, so the last capture wins.
            if (strobe) begin
                addr_q    <= addr_i;
                data_q    <= data_i;
                cap_vld_q <= 1'b1;
            end else if (rise) begin
                cap_vld_q <= 1'b0;
            end
        end
    end

    assign wr_o      = rise & cap_vld_q;
    assign wr_addr_o = addr_q;
    assign wr_data_o = data_q;

endmodule

// File: rtl/cart_bank_mapper.sv
// Cartridge bank mapper: banked windows with staged atomic 16-bit writes, a linear
// window, an optional AND mask and a key-sequence write lock on the mask registers.
module cart_bank_mapper
    import cart_mapper_pkg::*;
#(
    parameter int unsigned NUM_WINDOWS = 3,
    parameter int unsigned BANK_WIDTH  = 10,
    parameter logic [7:0]  REG_BASE    = 8'hD0,
    parameter logic [7:0]  EXT_BASE    = 8'hE4,
    parameter logic [7:0]  LINEAR_ADDR = 8'hC0
) (
    input  logic                   FastClk,
    input  logic                   Reset,
    input  logic                   nSel,
    input  logic                   nIO,
    input  logic                   nWE,
    input  logic [7:0]             RegAddr,
    input  logic [7:0]             WriteData,
    input  logic [3:0]             AddrHi,
    output logic [7:0]             ReadData,
    output logic                   RegAck,
    output logic [BANK_WIDTH-1:0]  BankOut,
    output logic [NUM_WINDOWS:0]   WindowHit,
    output logic                   Locked
);

    localparam logic [7:0] MASK_L_ADDR = EXT_BASE + EXT_MASK_L_OFS;
    localparam logic [7:0] MASK_H_ADDR = EXT_BASE + EXT_MASK_H_OFS;
    localparam logic [7:0] APPLY_ADDR  = EXT_BASE + EXT_APPLY_OFS;
    localparam logic [7:0] LOCK_ADDR   = EXT_BASE + EXT_LOCK_OFS;

    logic                                  wr;
    logic [7:0]                            wr_addr, wr_data;
    logic [NUM_WINDOWS-1:0][BANK_WIDTH-1:0] bank_q;
    logic [NUM_WINDOWS-1:0][7:0]           stage_q;
    logic [BANK_WIDTH-1:0]                 mask_q;
    logic [7:0]                            mask_stage_q;
    logic [NUM_WINDOWS:0]                  apply_q;
    logic [7:0]                            linear_q;
    lock_state_e                           state_q, state_d;
    logic [BANK_WIDTH-1:0]                 raw;
    logic                                  mask_en;

    bus_write_sync u_sync (
        .clk_i     (FastClk),
        .rst_i     (Reset),
        .nsel_i    (nSel),
        .nio_i     (nIO),
        .nwe_i     (nWE),
        .addr_i    (RegAddr),
        .data_i    (WriteData),
        .wr_o      (wr),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data)
    );

    assign Locked = (state_q != LK_UNLOCKED);

    always_ff @(posedge FastClk or posedge Reset) begin
        if (Reset) begin
            bank_q       <= '1;
            stage_q      <= '1;
            mask_q       <= '1;
            mask_stage_q <= '1;
            apply_q      <= '1;
            linear_q     <= 8'hFF;
        end else if (wr) begin
            for (int w = 0; w < NUM_WINDOWS; w++) begin
                if (wr_addr == REG_BASE + 8'(2 * w))
                    stage_q[w] <= wr_data;
                if (wr_addr == REG_BASE + 8'(2 * w + 1))
                    bank_q[w] <= {wr_data[BANK_WIDTH-9:0], stage_q[w]};
            end
            if (wr_addr == LINEAR_ADDR)
                linear_q <= wr_data;
            if (!Locked) begin
                if (wr_addr == MASK_L_ADDR) mask_stage_q <= wr_data;
                if (wr_addr == MASK_H_ADDR) mask_q <= {wr_data[BANK_WIDTH-9:0], mask_stage_q};
                if (wr_addr == APPLY_ADDR)  apply_q <= wr_data[NUM_WINDOWS:0];
            end
        end
    end

    always_ff @(posedge FastClk or posedge Reset) begin
        if (Reset) state_q <= LK_LOCKED;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (wr && wr_addr == LOCK_ADDR) begin
            case (state_q)
                LK_LOCKED:   if (wr_data == LOCK_KEY1) state_d = LK_KEY1;
                LK_KEY1:     state_d = (wr_data == LOCK_KEY2) ? LK_UNLOCKED : LK_LOCKED;
                LK_UNLOCKED: if (wr_data == LOCK_RELOCK) state_d = LK_LOCKED;
                default:     state_d = LK_LOCKED;
            endcase
        end
    end

    // Register reads expose committed values only; staging bytes are write-only.
    always_comb begin
        ReadData = '0;
        RegAck   = 1'b0;
        for (int w = 0; w < NUM_WINDOWS; w++) begin
            if (RegAddr == REG_BASE + 8'(2 * w)) begin
                RegAck   = 1'b1;
                ReadData = bank_q[w][7:0];
            end
            if (RegAddr == REG_BASE + 8'(2 * w + 1)) begin
                RegAck   = 1'b1;
                ReadData = 8'(bank_q[w][BANK_WIDTH-1:8]);
            end
        end
        if (RegAddr == MASK_L_ADDR) begin
            RegAck   = 1'b1;
            ReadData = mask_q[7:0];
        end
        if (RegAddr == MASK_H_ADDR) begin
            RegAck   = 1'b1;
            ReadData = 8'(mask_q[BANK_WIDTH-1:8]);
        end
        if (RegAddr == APPLY_ADDR) begin
            RegAck   = 1'b1;
            ReadData = 8'(apply_q);
        end
        if (RegAddr == LOCK_ADDR) begin
            RegAck   = 1'b1;
            ReadData = 8'(state_q);
        end
        if (RegAddr == LINEAR_ADDR) begin
            RegAck   = 1'b1;
            ReadData = linear_q;
        end
    end

    always_comb begin
        WindowHit = '0;
        raw       = '0;
        mask_en   = 1'b0;
        for (int w = 0; w < NUM_WINDOWS; w++) begin
            if (AddrHi == 4'(w + 1)) begin
                WindowHit[w] = 1'b1;
                raw          = bank_q[w];
                mask_en      = apply_q[w];
            end
        end
        if (AddrHi > 4'(NUM_WINDOWS)) begin
            WindowHit[NUM_WINDOWS] = 1'b1;
            raw                    = BANK_WIDTH'({linear_q, AddrHi});
            mask_en                = apply_q[NUM_WINDOWS];
        end
    end

    assign BankOut = mask_en ? (raw & mask_q) : raw;

endmodule

// File: tb/tb_cart_bank_mapper.sv
// Self-checking bench for cart_bank_mapper: directed scenarios plus random register
// traffic compared against an abstract register-file model.
module tb_cart_bank_mapper;
    import cart_mapper_pkg::*;

    localparam int NW = 3;
    localparam int BW = 10;
    localparam int unsigned BMASK = (1 << BW) - 1;

    logic          FastClk = 1'b0;
    logic          Reset = 1'b1;
    logic          nSel = 1'b1, nIO = 1'b1, nWE = 1'b1;
    logic [7:0]    RegAddr = 8'h00, WriteData = 8'h00;
    logic [3:0]    AddrHi = 4'h0;
    logic [7:0]    ReadData;
    logic          RegAck;
    logic [BW-1:0] BankOut;
    logic [NW:0]   WindowHit;
    logic          Locked;

    int total = 0;
    int bad = 0;

    cart_bank_mapper #(
        .NUM_WINDOWS(NW), .BANK_WIDTH(BW), .REG_BASE(8'hD0),
        .EXT_BASE(8'hE4), .LINEAR_ADDR(8'hC0)
    ) dut (
        .FastClk(FastClk), .Reset(Reset), .nSel(nSel), .nIO(nIO), .nWE(nWE),
        .RegAddr(RegAddr), .WriteData(WriteData), .AddrHi(AddrHi),
        .ReadData(ReadData), .RegAck(RegAck), .BankOut(BankOut),
        .WindowHit(WindowHit), .Locked(Locked)
    );

    always #5 FastClk = ~FastClk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Abstract model: the visible register file
    int unsigned m_bank[NW];
    int unsigned m_stage[NW];
    int unsigned m_mask, m_mstage, m_apply, m_lin;
    int          m_lk;

    function automatic void m_reset();
        for (int w = 0; w < NW; w++) begin
            m_bank[w]  = BMASK;
            m_stage[w] = 8'hFF;
        end
        m_mask = BMASK; m_mstage = 8'hFF;
        m_apply = (1 << (NW + 1)) - 1;
        m_lin = 8'hFF;
        m_lk = int'(LK_LOCKED);
    endfunction

    function automatic void m_write(input int a, input int unsigned d);
        bit unlocked;
        unlocked = (m_lk == int'(LK_UNLOCKED));
        for (int w = 0; w < NW; w++) begin
            if (a == 'hD0 + 2 * w) m_stage[w] = d;
            if (a == 'hD1 + 2 * w) m_bank[w] = ((d << 8) | m_stage[w]) & BMASK;
        end
        if (a == 'hC0) m_lin = d;
        if (unlocked && a == 'hE4) m_mstage = d;
        if (unlocked && a == 'hE5) m_mask = ((d << 8) | m_mstage) & BMASK;
        if (unlocked && a == 'hE6) m_apply = d & ((1 << (NW + 1)) - 1);
        if (a == 'hE7) begin
            if (m_lk == int'(LK_LOCKED)) begin
                if (d == 'h4E) m_lk = int'(LK_KEY1);
            end else if (m_lk == int'(LK_KEY1)) begin
                m_lk = (d == 'h53) ? int'(LK_UNLOCKED) : int'(LK_LOCKED);
            end else if (d == 'h00) begin
                m_lk = int'(LK_LOCKED);
            end
        end
    endfunction

    function automatic int unsigned exp_read(input int a, output bit ack);
        ack = 1'b1;
        for (int w = 0; w < NW; w++) begin
            if (a == 'hD0 + 2 * w) return m_bank[w] & 'hFF;
            if (a == 'hD1 + 2 * w) return m_bank[w] >> 8;
        end
        if (a == 'hC0) return m_lin;
        if (a == 'hE4) return m_mask & 'hFF;
        if (a == 'hE5) return m_mask >> 8;
        if (a == 'hE6) return m_apply;
        if (a == 'hE7) return m_lk;
        ack = 1'b0;
        return 0;
    endfunction

    function automatic int unsigned exp_bank(input int ahi, output int unsigned hit);
        int unsigned r;
        int idx;
        hit = 0;
        if (ahi == 0) return 0;
        if (ahi <= NW) begin
            idx = ahi - 1;
            r = m_bank[idx];
        end else begin
            idx = NW;
            r = ((m_lin << 4) | ahi) & BMASK;
        end
        hit = 1 << idx;
        if ((m_apply >> idx) & 1) r = r & m_mask;
        return r;
    endfunction

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge FastClk);
        RegAddr = a; WriteData = d; nSel = 1'b0; nIO = 1'b0; nWE = 1'b0;
        repeat (4) @(negedge FastClk);
        nWE = 1'b1; nSel = 1'b1; nIO = 1'b1;
        repeat (5) @(negedge FastClk);
        m_write(a, d);
    endtask

    task automatic do_reset();
        @(negedge FastClk);
        Reset = 1'b1;
        repeat (3) @(negedge FastClk);
        Reset = 1'b0;
        m_reset();
        repeat (2) @(negedge FastClk);
    endtask

    task automatic test_reset();
        int unsigned eb, eh;
        do_reset();
        for (int a = 1; a <= NW + 1; a++) begin
            AddrHi = 4'(a); #1;
            eb = exp_bank(a, eh);
            total++;
            if (BankOut !== BW'(eb) || WindowHit !== (NW+1)'(eh)) begin
                bad++;
                $display("FAIL reset_xlate ahi=%0d got=%h/%b exp=%h/%b", a, BankOut, WindowHit, eb, eh);
            end
        end
        total++;
        if (Locked !== 1'b1) begin bad++; $display("FAIL reset_locked got=%b exp=1", Locked); end
        RegAddr = 8'hD1; #1;
        total++;
        if (ReadData !== 8'h03 || RegAck !== 1'b1) begin
            bad++; $display("FAIL reset_bankh got=%h/%b exp=03/1", ReadData, RegAck);
        end
        RegAddr = 8'hE6; #1;
        total++;
        if (ReadData !== 8'h0F) begin bad++; $display("FAIL reset_apply got=%h exp=0f", ReadData); end
        RegAddr = 8'hC0; #1;
        total++;
        if (ReadData !== 8'hFF) begin bad++; $display("FAIL reset_linear got=%h exp=ff", ReadData); end
    endtask

    task automatic test_read_stage();
        bus_write(8'hD0, 8'h55);
        RegAddr = 8'hD0; #1;
        total++;
        if (ReadData !== 8'hFF || RegAck !== 1'b1) begin
            bad++; $display("FAIL stage_hidden got=%h/%b exp=ff/1", ReadData, RegAck);
        end
        RegAddr = 8'hFF; #1;
        total++;
        if (ReadData !== 8'h00 || RegAck !== 1'b0) begin
            bad++; $display("FAIL unmapped got=%h/%b exp=00/0", ReadData, RegAck);
        end
        bus_write(8'hD1, 8'h01);
        AddrHi = 4'd1; #1;
        total++;
        if (BankOut !== 10'h155) begin bad++; $display("FAIL commit_h got=%h exp=155", BankOut); end
        bus_write(8'hD1, 8'h02);
        AddrHi = 4'd1; #1;
        total++;
        if (BankOut !== 10'h255) begin bad++; $display("FAIL stage_reuse got=%h exp=255", BankOut); end
    endtask

    task automatic test_latency();
        int n;
        bit seen;
        bus_write(8'hD4, 8'h12);
        AddrHi = 4'd3;
        @(negedge FastClk);
        RegAddr = 8'hD5; WriteData = 8'h01; nSel = 1'b0; nIO = 1'b0; nWE = 1'b0;
        repeat (4) @(negedge FastClk);
        nWE = 1'b1; nSel = 1'b1; nIO = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 10) begin
            @(posedge FastClk); #1;
            n++;
            if (BankOut === 10'h112) seen = 1'b1;
        end
        m_write('hD5, 'h01);
        total++;
        if (!seen || n < 2 || n > 4) begin
            bad++; $display("FAIL commit_latency cycles=%0d seen=%b exp=2..4", n, seen);
        end
        repeat (3) @(negedge FastClk);
    endtask

    task automatic test_atomic();
        bus_write(8'hD2, 8'h34);
        AddrHi = 4'd2; #1;
        total++;
        if (BankOut !== 10'h3FF) begin bad++; $display("FAIL atomic_between got=%h exp=3ff", BankOut); end
        bus_write(8'hD3, 8'h02);
        AddrHi = 4'd2; #1;
        total++;
        if (BankOut !== 10'h234 || WindowHit !== 4'b0010) begin
            bad++; $display("FAIL atomic_after got=%h/%b exp=234/0010", BankOut, WindowHit);
        end
    endtask

    task automatic test_lock_mask();
        bus_write(8'hE4, 8'h0F);
        bus_write(8'hE5, 8'h00);
        RegAddr = 8'hE4; #1;
        total++;
        if (ReadData !== 8'hFF) begin bad++; $display("FAIL locked_mask_l got=%h exp=ff", ReadData); end
        AddrHi = 4'd3; #1;
        total++;
        if (BankOut !== 10'h112) begin bad++; $display("FAIL locked_mask_xlate got=%h exp=112", BankOut); end
        bus_write(8'hE7, 8'h4E);
        total++;
        if (Locked !== 1'b1) begin bad++; $display("FAIL key1_locked got=%b exp=1", Locked); end
        bus_write(8'hE7, 8'h53);
        total++;
        if (Locked !== 1'b0) begin bad++; $display("FAIL unlocked got=%b exp=0", Locked); end
        bus_write(8'hD4, 8'hFF);
        bus_write(8'hD5, 8'h03);
        bus_write(8'hE4, 8'h0F);
        bus_write(8'hE5, 8'h00);
        AddrHi = 4'd3; #1;
        total++;
        if (BankOut !== 10'h00F) begin bad++; $display("FAIL masked_xlate got=%h exp=00f", BankOut); end
    endtask

    task automatic test_bad_key();
        bus_write(8'hE7, 8'h00);
        bus_write(8'hE7, 8'h4E);
        bus_write(8'hE7, 8'h11);
        bus_write(8'hE7, 8'h53);
        RegAddr = 8'hE7; #1;
        total++;
        if (Locked !== 1'b1 || ReadData !== 8'(LK_LOCKED)) begin
            bad++; $display("FAIL bad_key got=%b/%h exp=1/%h", Locked, ReadData, 8'(LK_LOCKED));
        end
    endtask

    task automatic test_linear();
        bus_write(8'hE7, 8'h4E);
        bus_write(8'hE7, 8'h53);
        bus_write(8'hE6, 8'h00);
        bus_write(8'hC0, 8'h12);
        AddrHi = 4'd7; #1;
        total++;
        if (BankOut !== 10'h127 || WindowHit !== 4'b1000) begin
            bad++; $display("FAIL linear got=%h/%b exp=127/1000", BankOut, WindowHit);
        end
        AddrHi = 4'd0; #1;
        total++;
        if (BankOut !== 10'h000 || WindowHit !== 4'b0000) begin
            bad++; $display("FAIL no_hit got=%h/%b exp=000/0000", BankOut, WindowHit);
        end
    endtask

    task automatic test_reset_midwrite();
        do_reset();
        @(negedge FastClk);
        RegAddr = 8'hD1; WriteData = 8'h01; nSel = 1'b0; nIO = 1'b0; nWE = 1'b0;
        repeat (4) @(negedge FastClk);
        Reset = 1'b1;
        repeat (2) @(negedge FastClk);
        nWE = 1'b1; nSel = 1'b1; nIO = 1'b1;
        repeat (2) @(negedge FastClk);
        Reset = 1'b0;
        repeat (6) @(negedge FastClk);
        AddrHi = 4'd1; RegAddr = 8'hD1; #1;
        total++;
        if (BankOut !== 10'h3FF || ReadData !== 8'h03) begin
            bad++; $display("FAIL reset_midwrite got=%h/%h exp=3ff/03", BankOut, ReadData);
        end
    endtask

    task automatic test_random();
        logic [7:0] addrs [12] = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5,
                                   8'hC0, 8'hE4, 8'hE5, 8'hE6, 8'hE7, 8'hFF};
        logic [7:0] keys [4] = '{8'h4E, 8'h53, 8'h00, 8'h11};
        logic [7:0] a, d;
        int unsigned er, eb, eh;
        bit ack;
        int ahi;
        for (int i = 0; i < 40; i++) begin
            a = addrs[$urandom_range(11)];
            d = 8'($urandom);
            if (a == 8'hE7 && $urandom_range(3) != 0) d = keys[$urandom_range(3)];
            if (i < 4) begin a = 8'hE7; d = (i % 2 == 0) ? 8'h4E : 8'h53; end
            bus_write(a, d);
            RegAddr = addrs[$urandom_range(11)];
            ahi = int'($urandom_range(15));
            AddrHi = 4'(ahi); #1;
            er = exp_read(int'(RegAddr), ack);
            eb = exp_bank(ahi, eh);
            total++;
            if (ReadData !== 8'(er) || RegAck !== ack) begin
                bad++; $display("FAIL rnd_read addr=%h got=%h/%b exp=%h/%b", RegAddr, ReadData, RegAck, er, ack);
            end
            total++;
            if (BankOut !== BW'(eb) || WindowHit !== (NW+1)'(eh)) begin
                bad++; $display("FAIL rnd_xlate ahi=%0d got=%h/%b exp=%h/%b", ahi, BankOut, WindowHit, eb, eh);
            end
            total++;
            if (Locked !== (m_lk != int'(LK_UNLOCKED))) begin
                bad++; $display("FAIL rnd_locked got=%b exp=%b", Locked, m_lk != int'(LK_UNLOCKED));
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_read_stage();
        test_latency();
        test_atomic();
        test_lock_mask();
        test_bad_key();
        test_linear();
        test_reset_midwrite();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
